// File: rtl/vga_stream_driver.sv
// vga_stream_driver: parametrised VGA raster generator with a valid/ready
// pixel sink that locks the incoming stream to the raster on start-of-frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_SEEK   | discard beats until a start-of-frame beat is presented
// S_WAIT   | hold the start-of-frame beat until the raster reaches (0,0)
// S_STREAM | consume one beat per active pixel, flag gaps/misalignment
module vga_stream_driver #(
  parameter int CW       = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PW       = 10
) (
  input  logic            clk_pix,
  input  logic            rst_pix,
  input  logic            resync,
  input  logic            clr_underflow,
  input  logic [3*CW-1:0] s_data,
  input  logic            s_sof,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [CW-1:0]   vga_r,
  output logic [CW-1:0]   vga_g,
  output logic [CW-1:0]   vga_b,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic [PW-1:0]   sx,
  output logic [PW-1:0]   sy,
  output logic            frame_start,
  output logic            underflow,
  output logic [7:0]      frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [PW-1:0] H_LAST  = PW'(H_TOTAL - 1);
  localparam logic [PW-1:0] H_ACT   = PW'(H_ACTIVE);
  localparam logic [PW-1:0] HS_BEG  = PW'(H_ACTIVE + H_FP);
  localparam logic [PW-1:0] HS_LAST = PW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [PW-1:0] V_LAST  = PW'(V_TOTAL - 1);
  localparam logic [PW-1:0] V_ACT   = PW'(V_ACTIVE);
  localparam logic [PW-1:0] VS_BEG  = PW'(V_ACTIVE + V_FP);
  localparam logic [PW-1:0] VS_LAST = PW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    S_SEEK   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic            frame_wrap;
  logic            at_origin, active, hs_on, vs_on;
  logic            streaming, show, set_uf;

  logic [3*CW-1:0] rgb_q;
  logic            hsync_q, vsync_q, de_q, fs_q, uf_q;
  logic [PW-1:0]   sx_q, sy_q;
  logic [7:0]      fc_q;

  assign at_origin = (cx_q == '0) && (cy_q == '0);
  assign active    = (cx_q < H_ACT) && (cy_q < V_ACT);
  assign hs_on     = (cx_q >= HS_BEG) && (cx_q <= HS_LAST);
  assign vs_on     = (cy_q >= VS_BEG) && (cy_q <= VS_LAST);

  // Raster counter advance; resync snaps back to the origin without counting a frame.
  always_comb begin
    cx_d       = cx_q;
    cy_d       = cy_q;
    frame_wrap = 1'b0;
    if (resync) begin
      cx_d = '0;
      cy_d = '0;
    end else if (cx_q == H_LAST) begin
      cx_d = '0;
      if (cy_q == V_LAST) begin
        cy_d       = '0;
        frame_wrap = 1'b1;
      end else begin
        cy_d = cy_q + 1'b1;
      end
    end else begin
      cx_d = cx_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_pix or negedge rst_pix) begin
    if (!rst_pix) state_q <= S_SEEK;
    else          state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    if (resync) begin
      state_d = S_SEEK;
    end else begin
      unique case (state_q)
        S_SEEK:   if (s_valid && s_sof) state_d = S_WAIT;
        S_WAIT:   if (at_origin) state_d = S_STREAM;
        S_STREAM: if (active && s_valid && s_sof && !at_origin) state_d = S_WAIT;
        default:  state_d = S_SEEK;
      endcase
    end
  end

  // Handshake and pixel-outcome decode. At (0,0) a beat is expected to carry
  // sof; anywhere else it must not, so a mismatch of the two flags misalignment.
  always_comb begin
    s_ready   = 1'b0;
    streaming = 1'b0;
    set_uf    = 1'b0;
    show      = 1'b0;
    if (!resync) begin
      unique case (state_q)
        S_SEEK:   s_ready = !(s_valid && s_sof);
        S_WAIT: begin
          streaming = at_origin;
          s_ready   = at_origin;
        end
        S_STREAM: begin
          streaming = 1'b1;
          s_ready   = active && !(s_valid && s_sof && !at_origin);
        end
        default:  s_ready = 1'b0;
      endcase
    end
    if (streaming && active) begin
      set_uf = !s_valid || (s_sof != at_origin);
      show   = s_valid && s_ready;
    end
  end

  // Raster counters, status and the registered pin stage (one cycle behind cx/cy).
  always_ff @(posedge clk_pix or negedge rst_pix) begin
    if (!rst_pix) begin
      cx_q    <= '0;
      cy_q    <= '0;
      fc_q    <= 8'd0;
      uf_q    <= 1'b0;
      rgb_q   <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      fs_q    <= 1'b0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
      if (frame_wrap) fc_q <= fc_q + 8'd1;
      if (set_uf)                          uf_q <= 1'b1;
      else if (clr_underflow && !resync)   uf_q <= 1'b0;
      rgb_q   <= show ? s_data : '0;
      hsync_q <= hs_on ? HS_POL : ~HS_POL;
      vsync_q <= vs_on ? VS_POL : ~VS_POL;
      de_q    <= active;
      sx_q    <= cx_q;
      sy_q    <= cy_q;
      fs_q    <= at_origin;
    end
  end

  assign vga_r       = rgb_q[3*CW-1:2*CW];
  assign vga_g       = rgb_q[2*CW-1:CW];
  assign vga_b       = rgb_q[CW-1:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign sx          = sx_q;
  assign sy          = sy_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign frame_cnt   = fc_q;

endmodule
